// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package keypad_pkg;

   typedef enum logic [1:0] {SCAN, DEB_PRESS, PRESSED, DEB_REL} state_t;

   localparam int ROWS = 4;
   localparam int COLS = 4;
   localparam logic [ROWS-1:0] ROW_IDLE = 4'b1111;

   // Lowest-numbered active-low row wins when several rows are pulled low.
   function automatic logic [1:0] lowest_zero(input logic [ROWS-1:0] rows);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = ROWS - 1; i >= 0; i--) begin
         if (!rows[i]) idx = 2'(i);
      end
      return idx;
   endfunction

   function automatic logic [COLS-1:0] col_drive(input logic [1:0] c);
      return ~(COLS'(1) << c);
   endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer for the asynchronous row lines; resets to the idle pattern.
module sync2
   import keypad_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [ROWS-1:0] d,
   output logic [ROWS-1:0] q
);

   logic [ROWS-1:0] meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= ROW_IDLE;
         q    <= ROW_IDLE;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with press/release debounce and single-cycle key events.
//
//  state     | meaning
//  SCAN      | rotate the low column every SCAN_TICKS cycles, look for a pulled-low row
//  DEB_PRESS | column frozen, row pattern must stay identical for DEBOUNCE_CYCLES
//  PRESSED   | key accepted, key_held high, wait for all rows idle
//  DEB_REL   | rows must stay idle for DEBOUNCE_CYCLES, then resume scanning
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_TICKS      = 27000,
   parameter int DEBOUNCE_CYCLES = 270000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [ROWS-1:0] fila,
   output logic [COLS-1:0] columna,
   output logic [3:0]      key_code,
   output logic            key_valid,
   output logic            key_held
);

   localparam int DW = $clog2(SCAN_TICKS);
   localparam int BW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_TICKS - 1);
   localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CYCLES - 1);

   state_t          state;
   logic [1:0]      col;
   logic [1:0]      row;
   logic [DW-1:0]   dwell;
   logic [BW-1:0]   deb;
   logic [ROWS-1:0] pattern;
   logic [ROWS-1:0] fs;

   sync2 u_sync (
      .clk (clk),
      .rst (rst),
      .d   (fila),
      .q   (fs)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= SCAN;
         col       <= 2'd0;
         columna   <= col_drive(2'd0);
         row       <= 2'd0;
         dwell     <= '0;
         deb       <= '0;
         pattern   <= ROW_IDLE;
         key_code  <= 4'h0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         case (state)
            SCAN: begin
               if (dwell == DWELL_LAST) begin
                  dwell <= '0;
                  if (fs == ROW_IDLE) begin
                     col     <= col + 2'd1;
                     columna <= col_drive(col + 2'd1);
                  end else begin
                     row     <= lowest_zero(fs);
                     pattern <= fs;
                     deb     <= '0;
                     state   <= DEB_PRESS;
                  end
               end else begin
                  dwell <= dwell + 1'b1;
               end
            end
            DEB_PRESS: begin
               // Any change restarts the same column's dwell; the key must re-qualify.
               if (fs != pattern) begin
                  dwell <= '0;
                  state <= SCAN;
               end else if (deb == DEB_LAST) begin
                  key_code  <= {row, col};
                  key_valid <= 1'b1;
                  key_held  <= 1'b1;
                  state     <= PRESSED;
               end else begin
                  deb <= deb + 1'b1;
               end
            end
            PRESSED: begin
               if (fs == ROW_IDLE) begin
                  deb   <= '0;
                  state <= DEB_REL;
               end
            end
            DEB_REL: begin
               if (fs != ROW_IDLE) begin
                  state <= PRESSED;
               end else if (deb == DEB_LAST) begin
                  key_held <= 1'b0;
                  col      <= col + 2'd1;
                  columna  <= col_drive(col + 2'd1);
                  dwell    <= '0;
                  state    <= SCAN;
               end else begin
                  deb <= deb + 1'b1;
               end
            end
            default: state <= SCAN;
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench: physical keypad model drives fila, a behavioural model predicts outputs.
module tb_keypad_scanner;

   localparam int ST = 4;
   localparam int DB = 8;
   localparam int P_SCAN  = 0;
   localparam int P_PRESS = 1;
   localparam int P_HELD  = 2;
   localparam int P_REL   = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  fila;
   logic [3:0]  columna;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;

   logic [15:0] keys    = '0;
   logic        ovr_en  = 1'b0;
   logic [3:0]  ovr_val = 4'hF;
   logic [3:0]  kp_rows;

   int n_pass  = 0;
   int n_total = 0;
   int pulses  = 0;
   int cyc     = 0;

   keypad_scanner #(.SCAN_TICKS(ST), .DEBOUNCE_CYCLES(DB)) dut (
      .clk       (clk),
      .rst       (rst),
      .fila      (fila),
      .columna   (columna),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   always #5 clk = ~clk;

   // Pressed key (r,c) pulls row r low only while column c is driven low.
   always_comb begin
      kp_rows = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && (columna[c] === 1'b0)) kp_rows[r] = 1'b0;
   end
   assign fila = ovr_en ? ovr_val : kp_rows;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_total++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h want %0h", name, got, want);
   endtask

   function automatic int lowest_low(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (!v[i]) return i;
      return 0;
   endfunction

   // Behavioural model
   bit         m_ready = 0;
   int         m_phase, m_col, m_age, m_stable, m_row;
   logic [3:0] m_pat, m_code, m_s1, m_s2, fs, fin;
   bit         m_valid, m_held, rin;

   always begin
      @(posedge clk);
      fin = fila;
      rin = rst;
      cyc++;
      if (rin) begin
         m_ready = 1; m_phase = P_SCAN; m_col = 0; m_age = 0; m_stable = 0; m_row = 0;
         m_pat = 4'hF; m_code = 4'h0; m_s1 = 4'hF; m_s2 = 4'hF; m_valid = 0; m_held = 0;
      end else if (m_ready) begin
         fs = m_s2;
         m_s2 = m_s1;
         m_s1 = fin;
         m_valid = 0;
         if (m_phase == P_SCAN) begin
            m_age++;
            if (m_age == ST) begin
               m_age = 0;
               if (fs == 4'hF) m_col = (m_col + 1) % 4;
               else begin
                  m_pat = fs; m_row = lowest_low(fs); m_stable = 0; m_phase = P_PRESS;
               end
            end
         end else if (m_phase == P_PRESS) begin
            if (fs != m_pat) begin
               m_phase = P_SCAN; m_age = 0;
            end else begin
               m_stable++;
               if (m_stable == DB) begin
                  m_code = 4'(m_row * 4 + m_col); m_valid = 1; m_held = 1; m_phase = P_HELD;
               end
            end
         end else if (m_phase == P_HELD) begin
            if (fs == 4'hF) begin
               m_stable = 0; m_phase = P_REL;
            end
         end else begin
            if (fs != 4'hF) m_phase = P_HELD;
            else begin
               m_stable++;
               if (m_stable == DB) begin
                  m_held = 0; m_col = (m_col + 1) % 4; m_age = 0; m_phase = P_SCAN;
               end
            end
         end
      end
      #1;
      if (m_ready) begin
         check($sformatf("columna@%0d", cyc), 32'(columna), 32'(4'hF ^ (4'b0001 << m_col)));
         check($sformatf("key_valid@%0d", cyc), 32'(key_valid), 32'(m_valid));
         check($sformatf("key_held@%0d", cyc), 32'(key_held), 32'(m_held));
         check($sformatf("key_code@%0d", cyc), 32'(key_code), 32'(m_code));
         if (key_valid === 1'b1) pulses++;
      end
   end

   task automatic wait_valid(input int budget, output bit seen);
      seen = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(posedge clk); #1;
         if (key_valid === 1'b1) seen = 1;
      end
   endtask

   task automatic wait_held_fall(input int budget, output int n);
      n = budget + 1;
      for (int i = 1; i <= budget; i++) begin
         @(posedge clk); #1;
         if (key_held === 1'b0) begin
            n = i;
            break;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit         seen;
      int         n, p0;
      logic [3:0] exp_col;

      // Reset and free-running scan
      repeat (3) @(posedge clk);
      #1;
      check("rst_columna", 32'(columna), 32'(4'b1110));
      check("rst_code", 32'(key_code), 32'h0);
      check("rst_valid", 32'(key_valid), 32'h0);
      check("rst_held", 32'(key_held), 32'h0);
      @(negedge clk) rst = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         @(posedge clk); #1;
         exp_col = 4'hF ^ (4'b0001 << ((i / 4) % 4));
         check($sformatf("scan_rot%0d", i), 32'(columna), 32'(exp_col));
      end
      @(negedge clk);
      check("scan_no_pulse", 32'(pulses), 32'h0);

      // Clean press of row 2, col 1
      keys[9] = 1'b1;
      wait_valid(100, seen);
      check("clean_seen", 32'(seen), 32'h1);
      check("clean_code", 32'(key_code), 32'h9);
      check("clean_held_rise", 32'(key_held), 32'h1);
      repeat (10) @(posedge clk);
      #1;
      check("clean_held", 32'(key_held), 32'h1);
      @(negedge clk) keys = '0;
      wait_held_fall(40, n);
      check("clean_rel_cycles", 32'(n), 32'd11);
      check("clean_next_col", 32'(columna), 32'(4'b1011));
      @(negedge clk);
      check("clean_pulses", 32'(pulses), 32'd1);

      // Bouncing contact on row 0, col 0
      p0 = pulses;
      for (int i = 0; i < 10; i++) begin
         keys[0] = ~keys[0];
         repeat (3) @(negedge clk);
      end
      check("bounce_quiet", 32'(pulses - p0), 32'd0);
      keys[0] = 1'b1;
      wait_valid(80, seen);
      check("bounce_seen", 32'(seen), 32'h1);
      check("bounce_code", 32'(key_code), 32'h0);
      @(negedge clk) keys = '0;
      wait_held_fall(40, n);
      check("bounce_rel", 32'(n <= 40), 32'h1);
      @(negedge clk);
      check("bounce_pulses", 32'(pulses - p0), 32'd1);

      // Two rows in column 3
      p0 = pulses;
      keys[7]  = 1'b1;
      keys[15] = 1'b1;
      wait_valid(80, seen);
      check("two_seen", 32'(seen), 32'h1);
      check("two_code", 32'(key_code), 32'h7);
      repeat (5) @(negedge clk);
      keys = '0;
      wait_held_fall(40, n);
      check("two_rel", 32'(n <= 40), 32'h1);
      @(negedge clk);
      check("two_pulses", 32'(pulses - p0), 32'd1);

      // Release glitch on key row 1, col 1
      p0 = pulses;
      keys[5] = 1'b1;
      wait_valid(80, seen);
      check("glitch_seen", 32'(seen), 32'h1);
      check("glitch_code", 32'(key_code), 32'h5);
      @(negedge clk);
      ovr_en = 1'b1; ovr_val = 4'hF; keys = '0;
      repeat (5) @(negedge clk);
      ovr_val = 4'b1101;
      @(negedge clk);
      ovr_val = 4'hF;
      wait_held_fall(40, n);
      check("glitch_rel_cycles", 32'(n), 32'd11);
      @(negedge clk);
      ovr_en = 1'b0;
      check("glitch_pulses", 32'(pulses - p0), 32'd1);

      // Reset during press debounce
      p0 = pulses;
      keys[0] = 1'b1;
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(posedge clk); #1;
         if (m_phase == P_PRESS) seen = 1;
      end
      check("rstdeb_entered", 32'(seen), 32'h1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1; keys = '0;
      @(posedge clk); #1;
      check("rstdeb_columna", 32'(columna), 32'(4'b1110));
      check("rstdeb_valid", 32'(key_valid), 32'h0);
      check("rstdeb_held", 32'(key_held), 32'h0);
      check("rstdeb_code", 32'(key_code), 32'h0);
      @(negedge clk) rst = 1'b0;
      repeat (30) @(negedge clk);
      check("rstdeb_pulses", 32'(pulses - p0), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
